// File: rtl/arb_pkg.sv
// Shared definitions for the rr_arbiter slice: policy constants, FSM state
// encoding and a one-hot to binary index helper.
package arb_pkg;

   localparam int ARB_MODE_RR    = 0;
   localparam int ARB_MODE_FIXED = 1;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Input is expected to be zero or one-hot; zero encodes to index 0.
   function automatic int unsigned arb_onehot2bin(input logic [31:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: rotate the candidate vector so ptr sits at
// bit 0, isolate the lowest set bit, then rotate the one-hot back into place.
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic [N-1:0]   excl,
   output logic [N-1:0]   win,
   output logic           found
);

   logic [N-1:0]   cand;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_oh;
   logic [2*N-1:0] cand_dbl;
   logic [2*N-1:0] oh_dbl;

   assign cand     = req & ~excl;
   assign cand_dbl = {cand, cand};
   assign rot      = N'(cand_dbl >> ptr);

   // Two's-complement trick keeps only the lowest set bit.
   assign rot_oh   = rot & (~rot + N'(1));

   // Shifting the doubled one-hot left by ptr and keeping the upper half
   // undoes the rotation, including the wrap past N-1.
   assign oh_dbl   = {rot_oh, rot_oh} << ptr;
   assign win      = N'(oh_dbl >> N);
   assign found    = |cand;

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin / fixed-priority arbiter with locked, registered one-hot
// grants. Define ARB_GRANT_TIMEOUT_EN to bound how long one owner may hold.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MODE     = ARB_MODE_RR,
   parameter int IDW      = $clog2(N),
   parameter int MAX_HOLD = 16
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
);

   if (N < 2 || N > 32) begin : g_bad_n
      $error("rr_arbiter: N must lie in 2..32");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter: MAX_HOLD must lie in 2..255");
   end

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic [N-1:0]   pick_win;
   logic [IDW-1:0] pick_ptr;
   logic [IDW-1:0] win_idx;
   logic           pick_found;
   logic           owner_req;
   logic           others_req;
   logic           hold_expired;
   logic           do_pick;

   assign owner_req  = |(req & gnt_q);
   assign others_req = |(req & ~gnt_q);
   assign pick_ptr   = (MODE == ARB_MODE_RR) ? ptr_q : '0;

   // Excluding the current owner only matters on a forced hand-over; on a
   // normal release its request is already low.
   arb_rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .excl  (gnt_q),
      .win   (pick_win),
      .found (pick_found)
   );

   assign win_idx = IDW'(arb_onehot2bin(32'(pick_win)));

`ifdef ARB_GRANT_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;

   assign hold_expired = owner_req && others_req && (hold_q == HOLD_LAST);

   // Counter parks at HOLD_LAST so a late competitor triggers hand-over at once.
   always_comb begin
      hold_d = hold_q;
      if (do_pick && pick_found) begin
         hold_d = '0;
      end else if (owner_req && (hold_q != HOLD_LAST)) begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   assign hold_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      do_pick = 1'b0;

      case (state_q)
         ARB_IDLE:  do_pick = |req;
         ARB_GRANT: do_pick = !owner_req || hold_expired;
         default:   do_pick = 1'b0;
      endcase

      if (do_pick) begin
         if (pick_found) begin
            gnt_d   = pick_win;
            state_d = ARB_GRANT;
            if (MODE == ARB_MODE_RR) begin
               ptr_d = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
            end
         end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = IDW'(arb_onehot2bin(32'(gnt_q)));

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (round-robin, fixed priority, short
// hold limit) share one request bus and are tracked by a per-cycle model.
module tb_rr_arbiter;
   import arb_pkg::*;

   localparam int ND = 3;
`ifdef ARB_GRANT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock   = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] req     = '0;

   logic [3:0] gnt_rr, gnt_fx, gnt_to;
   logic       valid_rr, valid_fx, valid_to;
   logic [1:0] id_rr, id_fx, id_to;

   logic [3:0] gnt_w   [ND];
   logic       valid_w [ND];
   logic [1:0] id_w    [ND];

   int mode_of [ND] = '{0, 1, 0};
   int hold_of [ND] = '{16, 16, 4};
   int m_owner [ND];
   int m_ptr   [ND];
   int m_hold  [ND];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   rr_arbiter #(.N(4), .MODE(ARB_MODE_RR)) dut_rr (
      .clock(clock), .reset_n(reset_n), .req(req),
      .gnt(gnt_rr), .gnt_valid(valid_rr), .gnt_id(id_rr));

   rr_arbiter #(.N(4), .MODE(ARB_MODE_FIXED)) dut_fx (
      .clock(clock), .reset_n(reset_n), .req(req),
      .gnt(gnt_fx), .gnt_valid(valid_fx), .gnt_id(id_fx));

   rr_arbiter #(.N(4), .MODE(ARB_MODE_RR), .MAX_HOLD(4)) dut_to (
      .clock(clock), .reset_n(reset_n), .req(req),
      .gnt(gnt_to), .gnt_valid(valid_to), .gnt_id(id_to));

   assign gnt_w[0] = gnt_rr;   assign valid_w[0] = valid_rr;   assign id_w[0] = id_rr;
   assign gnt_w[1] = gnt_fx;   assign valid_w[1] = valid_fx;   assign id_w[1] = id_fx;
   assign gnt_w[2] = gnt_to;   assign valid_w[2] = valid_to;   assign id_w[2] = id_to;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Round-robin scans upward from start with wrap; fixed priority scans from 0.
   function automatic int model_pick(input int mode, input logic [3:0] r,
                                     input int start, input int skip);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (mode == 0) ? (start + k) % 4 : k;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   // Model: owner index (-1 = none), search start and cycles held so far.
   always @(posedge clock or negedge reset_n) begin
      int o, nx;
      bit others;
      if (!reset_n) begin
         for (int d = 0; d < ND; d++) begin
            m_owner[d] <= -1;
            m_ptr[d]   <= 0;
            m_hold[d]  <= 0;
         end
      end else begin
         for (int d = 0; d < ND; d++) begin
            o  = m_owner[d];
            nx = o;
            others = 1'b0;
            for (int i = 0; i < 4; i++) if (req[i] && i != o) others = 1'b1;
            if (o < 0)
               nx = model_pick(mode_of[d], req, m_ptr[d], -1);
            else if (!req[o])
               nx = model_pick(mode_of[d], req, m_ptr[d], o);
            else if (TO_EN && others && m_hold[d] >= hold_of[d] - 1)
               nx = model_pick(mode_of[d], req, m_ptr[d], o);
            if (nx >= 0 && nx != o) begin
               m_hold[d] <= 0;
               if (mode_of[d] == 0) m_ptr[d] <= (nx + 1) % 4;
            end else if (nx >= 0 && m_hold[d] < hold_of[d] - 1) begin
               m_hold[d] <= m_hold[d] + 1;
            end
            m_owner[d] <= nx;
         end
      end
   end

   always @(negedge clock) begin
      logic [3:0] eg;
      for (int d = 0; d < ND; d++) begin
         eg = '0;
         if (m_owner[d] >= 0) eg[m_owner[d]] = 1'b1;
         chk($sformatf("model_gnt[%0d]", d), 32'(gnt_w[d]), 32'(eg));
         chk($sformatf("model_valid[%0d]", d), 32'(valid_w[d]), 32'(m_owner[d] >= 0));
         chk($sformatf("model_id[%0d]", d), 32'(id_w[d]),
             (m_owner[d] >= 0) ? 32'(m_owner[d]) : 32'd0);
      end
   end

   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clock);
      #1;
   endtask

   logic [3:0] t2_req [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] t2_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] to_exp;

   initial begin
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_gnt",   32'(gnt_rr),   32'h0);
      chk("reset_valid", 32'(valid_rr), 32'h0);
      chk("reset_id",    32'(id_rr),    32'h0);
      reset_n = 1'b1;

      // Idle latency
      step(4'b0000);  chk("idle_gnt0", 32'(gnt_rr), 32'h0);
      step(4'b0100);  chk("idle_gnt",  32'(gnt_rr), 32'h4);
      chk("idle_valid", 32'(valid_rr), 32'h1);
      chk("idle_id",    32'(id_rr),    32'h2);
      step(4'b0000);  chk("idle_release", 32'(gnt_rr), 32'h0);
      chk("idle_release_valid", 32'(valid_rr), 32'h0);

      // Lock while owner keeps requesting
      step(4'b0010);  chk("lock_first", 32'(gnt_rr), 32'h2);
      for (int k = 0; k < 10; k++) begin
         step(4'b0011);
         chk("lock_hold", 32'(gnt_rr), 32'h2);
      end
      step(4'b0001);  chk("lock_handover", 32'(gnt_rr), 32'h1);
      chk("lock_handover_id", 32'(id_rr), 32'h0);
      step(4'b0000);

      // Asynchronous reset in the middle of a grant
      step(4'b0100);  chk("pre_reset_gnt", 32'(gnt_rr), 32'h4);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_gnt",   32'(gnt_rr),   32'h0);
      chk("async_rst_valid", 32'(valid_rr), 32'h0);
      chk("async_rst_id",    32'(id_rr),    32'h0);
      chk("async_rst_fx",    32'(gnt_fx),   32'h0);
      req = 4'b0000;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // Round-robin fairness: each owner drops for one cycle once granted
      for (int k = 0; k < 5; k++) begin
         step(t2_req[k]);
         chk($sformatf("rr_order[%0d]", k), 32'(gnt_rr), 32'(t2_gnt[k]));
      end
      step(4'b0000);  chk("rr_idle", 32'(gnt_rr), 32'h0);

      // Fixed priority
      step(4'b1000);  chk("fx_first", 32'(gnt_fx), 32'h8);
      step(4'b0110);  chk("fx_low",   32'(gnt_fx), 32'h2);
      step(4'b0100);  chk("fx_next",  32'(gnt_fx), 32'h4);
      chk("fx_next_id", 32'(id_fx), 32'h2);
      step(4'b0000);  chk("fx_idle",  32'(gnt_fx), 32'h0);

      // Hold limit of 4 with a competitor, then alone
      step(4'b0001);  chk("to_first", 32'(gnt_to), 32'h1);
      for (int k = 0; k < 3; k++) begin
         step(4'b0011);
         chk("to_hold", 32'(gnt_to), 32'h1);
      end
      to_exp = TO_EN ? 4'b0010 : 4'b0001;
      step(4'b0011);  chk("to_expire", 32'(gnt_to), 32'(to_exp));
      step(4'b0000);
      step(4'b0001);
      for (int k = 0; k < 8; k++) begin
         step(4'b0001);
         chk("to_alone", 32'(gnt_to), 32'h1);
      end
      step(4'b0000);
      @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Parametrised N-way arbiter that replaces the fixed two-requester arbiter in shared-resource paths (bus masters, memory ports). It supports round-robin or fixed-priority selection and registered one-hot grants. A grant locks to its owner while the owner's request stays high, and hands over with no idle cycle when the owner releases.

Parameters:
N, 4, number of requesters; legal range 2..32
MODE, 0, arbitration policy; 0 = round-robin, 1 = fixed priority (lowest index wins)
IDW, $clog2(N), width of gnt_id; derived, never overridden
MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only with ARB_GRANT_TIMEOUT_EN; legal range 2..255

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  N  request vector; bit i is asserted by requester i
gnt  output  N  registered one-hot grant; all zeros when no grant is active
gnt_valid  output  1  high when any gnt bit is set
gnt_id  output  IDW  binary index of the current owner; 0 when gnt_valid is low

Behaviour:
- Reset: while reset_n is low, gnt=0, gnt_valid=0, gnt_id=0, ptr=0, state=IDLE. Reset applies immediately, including mid-grant.
- Invariant: gnt is always zero or one-hot. gnt_valid is the OR of gnt. gnt_id is the encoding of gnt.
- State IDLE:
  - When req is nonzero at a clock edge, the winner is granted at that edge and gnt is visible in the following cycle. Latency is 1 clock.
  - Transition to GRANT.
  - When req is zero, remain in IDLE.
- State GRANT, owner o:
  - While req[o]=1, gnt holds, even if higher-priority requests arrive.
  - When req[o]=0 and other requests are pending, a new winner is selected at the same edge. gnt moves directly from o to the winner with no zero cycle.
  - When req[o]=0 and no other request is pending, gnt=0 and state returns to IDLE.
- Round-robin selection (MODE=0):
  - Search starts at ptr and wraps from N-1 to 0. The first set req bit wins.
  - On each new grant, ptr becomes (winner+1) mod N.
  - A requester that just released is searched last, unless it is the only one requesting.
- Fixed-priority selection (MODE=1): the lowest set index wins. ptr is unused and stays 0.
- A requester that deasserts and reasserts in the same cycle in which it is granted keeps the grant. Only the level of req is sampled; there is no edge detection.
- Requests are level-sensitive and must be held until granted. Dropping a request before grant is legal and simply removes it from the next selection.

Optional Feature:
Macro ARB_GRANT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments on each cycle the owner keeps the grant.
  - When the counter reaches MAX_HOLD-1 while req[o]=1 and another request is pending, the grant is forcibly re-arbitrated at the next edge with o excluded from that selection. o competes normally afterwards.
  - With no other request pending, the counter saturates and the grant holds.
- Undefined: no counter exists, and grants hold indefinitely while req[o]=1.

Decomposition:
- Package arb_pkg holds:
  - the MODE constants ARB_MODE_RR=0 and ARB_MODE_FIXED=1
  - the state encoding, ARB_IDLE and ARB_GRANT
  - a onehot-to-binary encoding function
- One sub-module, arb_rr_pick: combinational. Inputs are the req vector, ptr and an exclude mask; outputs are the one-hot winner and a found flag. It is implemented as a double-width vector rotate-and-priority-encode.
- The rr_arbiter top holds the state register, ptr, the output registers and the optional hold counter.

Test Plan:
1. Reset mid-grant (N=4, MODE=0): owner 2 granted; drop reset_n asynchronously -> gnt=0000, gnt_valid=0, gnt_id=0 without waiting for a clock edge.
2. Round-robin fairness (N=4, MODE=0): req=1111 held, each owner drops its req for 1 cycle after being granted -> grant order 0,1,2,3,0; no zero-grant gap between owners.
3. Lock (N=4, MODE=0): req=0010 granted; then req=0011 for 10 cycles -> gnt stays 0010; req drops to 0001 -> next cycle gnt=0001, gnt_id=0.
4. Fixed priority (N=4, MODE=1): req=1000 granted; release with req=0110 pending -> gnt=0010; release again with req=0100 -> gnt=0100.
5. Idle latency (N=4, MODE=0): req=0000 then req=0100 at edge k -> gnt=0100 and gnt_valid=1 after edge k; req=0000 -> gnt=0000 after the next edge.
6. Timeout (ARB_GRANT_TIMEOUT_EN, MAX_HOLD=4, N=4): req=0001 held and req=0010 raised -> gnt 0001 for exactly 4 cycles, then 0010; with only req=0001 -> gnt 0001 holds beyond 4 cycles.
